pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor of the fixed-width EX/MEM latch; generic pipeline-stage register for any boundary (ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of WIDTH bits, which the stage wrappers pack.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure never drops or duplicates a payload.
- Flush inserts an all-zero bubble, in which control bits are deasserted.

Parameters:
- WIDTH, 133, payload width in bits; legal range 1..1024.
- RESET_VAL, 0, payload value on clr/flush, WIDTH bits wide.

Ports:
- clk  in  1  clock; all state changes on the posedge.
- clr  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous kill of all buffered entries (branch/jump redirect).
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage accepts this cycle; registered.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is valid; registered.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  payload of the head entry; registered, no combinational path from in_data.
- occupancy  out  2  entries held, 0..2.

Behaviour:
- Storage: main register (head, drives out_data) and skid register.
- FSM states:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - BUSY: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions:
  - EMPTY: accept → BUSY, main ← in_data. Otherwise stay.
  - BUSY:
    - accept & drain → BUSY, main ← in_data.
    - accept & !drain → FULL, skid ← in_data.
    - !accept & drain → EMPTY.
    - Otherwise stay.
  - FULL:
    - drain → BUSY, main ← skid.
    - Otherwise stay; in_valid is ignored because in_ready=0.
- Latency: 1 cycle from accept to out_valid in EMPTY. Throughput is 1 payload/cycle while out_ready=1.
- Ordering: strictly FIFO; a skid payload always leaves before any later accepted payload.
- In EMPTY, out_data equals RESET_VAL.
  - On transition to EMPTY, main ← RESET_VAL.
  - Bubbles are therefore all-zero with default RESET_VAL.
- Reset (clr=1, asynchronous):
  - State EMPTY; main and skid ← RESET_VAL.
  - out_valid 0, in_ready 1, occupancy 0, out_data RESET_VAL.
  - Reset mid-transfer discards both entries with no partial update.
- Flush (synchronous, highest priority after clr):
  - Next state EMPTY; main and skid ← RESET_VAL.
  - An accept in the flush cycle is discarded; the upstream handshake is still considered complete.
  - A drain in the flush cycle is a valid transfer: downstream keeps the current out_data.
- Priority: clr > flush > handshake.
- Stall: out_ready=0 holds out_data stable. It is legal to hold until FULL, then in_ready drops on the next edge.
- Rule: in_data must be held while in_valid=1 and in_ready=0. The block does not check this.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, adds output ports:
  - stall_cnt [31:0]: counts cycles with out_valid=1 and out_ready=0.
  - flush_cnt [15:0]: counts flush cycles in which occupancy>0.
- Both counters saturate at all-ones, reset to 0 on clr, and are unaffected by flush.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state typedef: EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
  - Constant EXMEM_W=133.
  - EX/MEM field offsets: zero 0, RegWrite 1, MemToReg 2, MemWrite 3, BranchEq 4, Jump 5, writeReg 10:6, alu_out 42:11, writeData 74:43, pcBranch 106:75, pcJump 132:107.
- Sub-module pipe_sat_counter (parametrised width, saturating, clr/inc) is instantiated only under PIPE_STAGE_PERF_EN.

Test Plan:
1. Reset: assert clr mid-cycle with state FULL → immediately out_valid=0, in_ready=1, occupancy=0, out_data=0, without waiting for a clk edge.
2. Streaming: WIDTH=133, out_ready=1, push 0x1..0x8 back-to-back → out_data 0x1..0x8 on consecutive cycles, each 1 cycle after accept, occupancy ≤1.
3. Back-pressure: push 0xA, 0xB with out_ready=0 → occupancy=2 and in_ready=0 from the next edge. Then raise out_ready → 0xA then 0xB, no loss or duplication.
4. Flush in FULL with in_valid=1 carrying 0xC → next cycle occupancy=0, out_valid=0, out_data=0. 0xC is never output.
5. Flush with a simultaneous drain of 0xD → the consumer captures 0xD; the stage is EMPTY next cycle.
6. PIPE_STAGE_PERF_EN: hold out_valid=1 and out_ready=0 for 5 cycles, then flush while occupied → stall_cnt=5, flush_cnt=1. Force stall_cnt near max → it saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: skid FSM state encoding and the EX/MEM payload layout
// packed by the stage wrappers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned EXMEM_W = 133;

    // EX/MEM field offsets (LSB/MSB, inclusive)
    localparam int unsigned EXMEM_ZERO_BIT      = 0;
    localparam int unsigned EXMEM_REGWRITE_BIT  = 1;
    localparam int unsigned EXMEM_MEMTOREG_BIT  = 2;
    localparam int unsigned EXMEM_MEMWRITE_BIT  = 3;
    localparam int unsigned EXMEM_BRANCHEQ_BIT  = 4;
    localparam int unsigned EXMEM_JUMP_BIT      = 5;
    localparam int unsigned EXMEM_WREG_LSB      = 6;
    localparam int unsigned EXMEM_WREG_MSB      = 10;
    localparam int unsigned EXMEM_ALUOUT_LSB    = 11;
    localparam int unsigned EXMEM_ALUOUT_MSB    = 42;
    localparam int unsigned EXMEM_WDATA_LSB     = 43;
    localparam int unsigned EXMEM_WDATA_MSB     = 74;
    localparam int unsigned EXMEM_PCBRANCH_LSB  = 75;
    localparam int unsigned EXMEM_PCBRANCH_MSB  = 106;
    localparam int unsigned EXMEM_PCJUMP_LSB    = 107;
    localparam int unsigned EXMEM_PCJUMP_MSB    = 132;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline-stage boundary (upstream and downstream sides).
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = EXMEM_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, async active-high clr.
module pipe_sat_counter #(
    parameter int unsigned W = 32
)(
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a 2-entry skid buffer and flush-to-bubble.
// Define PIPE_STAGE_PERF_EN to add saturating stall/flush performance counters.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned     WIDTH     = EXMEM_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic clk,
    input  logic clr,
    input  logic flush,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    pipe_stage_skid_if.slave bus
);
    pipe_state_e      r_state;
    pipe_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             r_out_valid;
    logic             r_in_ready;
    logic [1:0]       r_occ;
    logic             w_out_valid_nxt;
    logic             w_in_ready_nxt;
    logic [1:0]       w_occ_nxt;
    logic             w_accept;
    logic             w_drain;

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_drain  = r_out_valid & bus.out_ready;

    // Next state and storage; handshake status flags are decoded from the next state
    always_comb begin
        w_state_nxt     = r_state;
        w_main_nxt      = r_main;
        w_skid_nxt      = r_skid;
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_occ_nxt       = 2'd0;

        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = RESET_VAL;
            w_skid_nxt  = RESET_VAL;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = BUSY;
                        w_main_nxt  = bus.in_data;
                    end
                end
                BUSY: begin
                    if (w_accept && w_drain) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_accept) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = bus.in_data;
                    end else if (w_drain) begin
                        w_state_nxt = EMPTY;
                        w_main_nxt  = RESET_VAL;
                    end
                end
                FULL: begin
                    if (w_drain) begin
                        w_state_nxt = BUSY;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_main_nxt  = RESET_VAL;
                    w_skid_nxt  = RESET_VAL;
                end
            endcase
        end

        case (w_state_nxt)
            BUSY: begin
                w_out_valid_nxt = 1'b1;
                w_occ_nxt       = 2'd1;
            end
            FULL: begin
                w_out_valid_nxt = 1'b1;
                w_in_ready_nxt  = 1'b0;
                w_occ_nxt       = 2'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_occ       <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_main      <= w_main_nxt;
            r_skid      <= w_skid_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_occ       <= w_occ_nxt;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.out_data  = r_main;
    assign bus.occupancy = r_occ;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .clr (clr),
        .inc (r_out_valid & ~bus.out_ready),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.W(16)) u_flush_cnt (
        .clk (clk),
        .clr (clr),
        .inc (flush & (r_occ != 2'd0)),
        .cnt (flush_cnt)
    );
`endif
endmodule
